// File: rtl/reaction_timer_core_if.sv
// Signal bundle between the reaction timer core and its surroundings:
// debounced start/button inputs in, stimulus LED and round result out.
interface reaction_timer_core_if;
    logic        start;
    logic        btn;
    logic        led;
    logic [13:0] time_ms;
    logic        done;
    logic        early;
    logic        timeout;
    logic        busy;

    modport master (
        output start, btn,
        input  led, time_ms, done, early, timeout, busy
    );

    modport slave (
        input  start, btn,
        output led, time_ms, done, early, timeout, busy
    );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction timer round engine: pseudo-random stimulus delay, 1 ms timebase,
// reaction time measurement with early-press and timeout detection.
module reaction_timer_core #(
    parameter int TICK_DIV    = 50000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int WAIT_MASK   = 2047,
    parameter int MAX_MS      = 9999
) (
    input logic                  cin,
    input logic                  rst,
    reaction_timer_core_if.slave bus
);
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [13:0]     MAX_T      = 14'(MAX_MS);
    localparam logic [16:0]     MIN_W      = 17'(MIN_WAIT_MS);
    localparam logic [15:0]     MASK_W     = 16'(WAIT_MASK);
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ARMED  = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] sh;
        sh = {1'b0, v[15:1]};
        return v[0] ? (sh ^ LFSR_TAPS) : sh;
    endfunction

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= MAX_T) ? MAX_T : (v + 14'd1);
    endfunction

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [15:0]   lfsr_r;
    logic          btn_q_r;
    logic [16:0]   ms_cnt_r, ms_cnt_s;
    logic [16:0]   target_r, target_s;
    logic [13:0]   time_ms_r, time_ms_s, time_inc_s;
    logic          led_r, led_s;
    logic          done_r, done_s;
    logic          early_r, early_s;
    logic          timeout_r, timeout_s;
    logic          busy_r, busy_s;
    logic          tick_s, press_s;

    assign tick_s  = (presc_r == PRESC_LAST);
    assign press_s = bus.btn & ~btn_q_r;

    // Next-state and next-output decode for the round FSM.
    always_comb begin
        state_s    = state_r;
        presc_s    = tick_s ? '0 : (presc_r + PRESC_ONE);
        ms_cnt_s   = ms_cnt_r;
        target_s   = target_r;
        time_ms_s  = time_ms_r;
        early_s    = early_r;
        timeout_s  = timeout_r;
        done_s     = 1'b0;
        time_inc_s = tick_s ? sat_inc(time_ms_r) : time_ms_r;

        case (state_r)
            IDLE, RESULT: begin
                if (bus.start) begin
                    state_s   = WAIT;
                    presc_s   = '0;
                    ms_cnt_s  = 17'd0;
                    target_s  = MIN_W + {1'b0, lfsr_r & MASK_W};
                    time_ms_s = 14'd0;
                    early_s   = 1'b0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT: begin
                // A press on the same cycle as the final tick still counts as early.
                if (press_s) begin
                    state_s   = RESULT;
                    early_s   = 1'b1;
                    time_ms_s = 14'd0;
                    done_s    = 1'b1;
                end else if (tick_s) begin
                    ms_cnt_s = ms_cnt_r + 17'd1;
                    if ((ms_cnt_r + 17'd1) >= target_r) begin
                        state_s   = ARMED;
                        presc_s   = '0;
                        time_ms_s = 14'd0;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            ARMED: begin
                if (press_s) begin
                    state_s   = RESULT;
                    time_ms_s = time_inc_s;
                    done_s    = 1'b1;
                end else if (tick_s) begin
                    time_ms_s = time_inc_s;
                    if (time_inc_s == MAX_T) begin
                        state_s   = RESULT;
                        timeout_s = 1'b1;
                        done_s    = 1'b1;
                    end else begin
                        state_s = ARMED;
                    end
                end else begin
                    state_s = ARMED;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        led_s  = (state_s == ARMED);
        busy_s = (state_s == WAIT) || (state_s == ARMED);
    end

    // State, timebase, LFSR and registered outputs.
    always_ff @(posedge cin) begin
        if (rst) begin
            state_r   <= IDLE;
            presc_r   <= '0;
            lfsr_r    <= LFSR_SEED;
            btn_q_r   <= 1'b0;
            ms_cnt_r  <= 17'd0;
            target_r  <= 17'd0;
            time_ms_r <= 14'd0;
            led_r     <= 1'b0;
            done_r    <= 1'b0;
            early_r   <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            lfsr_r    <= lfsr_step(lfsr_r);
            btn_q_r   <= bus.btn;
            ms_cnt_r  <= ms_cnt_s;
            target_r  <= target_s;
            time_ms_r <= time_ms_s;
            led_r     <= led_s;
            done_r    <= done_s;
            early_r   <= early_s;
            timeout_r <= timeout_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.led     = led_r;
    assign bus.time_ms = time_ms_r;
    assign bus.done    = done_r;
    assign bus.early   = early_r;
    assign bus.timeout = timeout_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: table of single-round scenarios,
// hand sequences for reset, held button and randomised wait spread.
module tb_reaction_timer_core;
    logic cin;
    logic rst;
    int   checks;
    int   failures;

    reaction_timer_core_if bus1 ();
    reaction_timer_core_if bus2 ();

    reaction_timer_core #(
        .TICK_DIV(4), .MIN_WAIT_MS(2), .WAIT_MASK(0), .MAX_MS(5)
    ) dut (
        .cin(cin), .rst(rst), .bus(bus1)
    );

    reaction_timer_core #(
        .TICK_DIV(2), .MIN_WAIT_MS(2), .WAIT_MASK(2047), .MAX_MS(5)
    ) dut_rnd (
        .cin(cin), .rst(rst), .bus(bus2)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int press_at;     // edge index after the start edge where btn rises; -1 = never
        int btn_held;     // btn high before start and held for the whole round
        int spam_start;   // extra start pulses at edges 4 (WAIT) and 12 (ARMED)
        int exp_done_k;
        int exp_led_k;    // -1 = led must never rise
        int exp_time;
        int exp_early;
        int exp_timeout;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge cin);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_round(input vec_t v, input int row);
        int   led_k;
        int   done_k;
        int   led_rises;
        logic led_prev;
        logic [13:0] t_cap;
        logic e_cap;
        logic to_cap;
        logic led_cap;
        string p;
        p = $sformatf("row%0d", row);
        led_k = -1; done_k = -1; led_rises = 0; led_prev = 1'b0;
        t_cap = '0; e_cap = 1'b0; to_cap = 1'b0; led_cap = 1'b0;

        bus1.btn = (v.btn_held != 0);
        step();
        step();
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        check({p, "_busy0"},  32'(bus1.busy), 32'd1);
        check({p, "_early0"}, 32'(bus1.early), 32'd0);
        check({p, "_tmo0"},   32'(bus1.timeout), 32'd0);
        check({p, "_time0"},  32'(bus1.time_ms), 32'd0);

        for (int k = 1; k <= 60 && done_k < 0; k++) begin
            bus1.btn   = (v.btn_held != 0) || (v.press_at >= 0 && k >= v.press_at);
            bus1.start = (v.spam_start != 0) && (k == 4 || k == 12);
            step();
            if (bus1.led && !led_prev) begin
                led_rises++;
                if (led_k < 0) led_k = k;
            end
            led_prev = bus1.led;
            if (bus1.done) begin
                done_k  = k;
                t_cap   = bus1.time_ms;
                e_cap   = bus1.early;
                to_cap  = bus1.timeout;
                led_cap = bus1.led;
            end
        end
        bus1.start = 1'b0;

        check({p, "_done_cycle"}, 32'(done_k), 32'(v.exp_done_k));
        check({p, "_led_cycle"},  32'(led_k), 32'(v.exp_led_k));
        check({p, "_led_rises"},  32'(led_rises), (v.exp_led_k >= 0) ? 32'd1 : 32'd0);
        check({p, "_time_ms"},    32'(t_cap), 32'(v.exp_time));
        check({p, "_early"},      32'(e_cap), 32'(v.exp_early));
        check({p, "_timeout"},    32'(to_cap), 32'(v.exp_timeout));
        check({p, "_led_at_done"}, 32'(led_cap), 32'd0);

        // Result phase: done drops after one cycle, results held.
        bus1.btn = 1'b0;
        step();
        check({p, "_done_pulse"}, 32'(bus1.done), 32'd0);
        check({p, "_busy_res"},   32'(bus1.busy), 32'd0);
        check({p, "_hold_time"},  32'(bus1.time_ms), 32'(v.exp_time));
        check({p, "_hold_early"}, 32'(bus1.early), 32'(v.exp_early));
        check({p, "_hold_tmo"},   32'(bus1.timeout), 32'(v.exp_timeout));
    endtask

    initial begin
        int   waits [16];
        int   k;
        int   all_same;
        vec_t held;

        checks = 0;
        failures = 0;

        vecs[0] = '{21, 0, 0, 21,  8, 3, 0, 0};
        vecs[1] = '{ 3, 0, 0,  3, -1, 0, 1, 0};
        vecs[2] = '{-1, 0, 0, 28,  8, 5, 0, 1};
        vecs[3] = '{26, 0, 0, 26,  8, 4, 0, 0};
        vecs[4] = '{28, 0, 0, 28,  8, 5, 0, 0};
        vecs[5] = '{ 8, 0, 0,  8, -1, 0, 1, 0};
        vecs[6] = '{ 9, 0, 0,  9,  8, 0, 0, 0};
        vecs[7] = '{-1, 0, 1, 28,  8, 5, 0, 1};
        vecs[8] = '{14, 0, 1, 14,  8, 1, 0, 0};
        held    = '{-1, 1, 0, 28,  8, 5, 0, 1};

        rst = 1'b1;
        bus1.start = 1'b0; bus1.btn = 1'b0;
        bus2.start = 1'b0; bus2.btn = 1'b0;

        // Reset with random stimulus: everything reads zero after each reset edge.
        for (int i = 0; i < 2; i++) begin
            bus1.start = 1'($urandom_range(1, 0));
            bus1.btn   = 1'($urandom_range(1, 0));
            step();
            check("rst_led",   32'(bus1.led), 32'd0);
            check("rst_done",  32'(bus1.done), 32'd0);
            check("rst_busy",  32'(bus1.busy), 32'd0);
            check("rst_early", 32'(bus1.early), 32'd0);
            check("rst_tmo",   32'(bus1.timeout), 32'd0);
            check("rst_time",  32'(bus1.time_ms), 32'd0);
        end
        rst = 1'b0;
        bus1.start = 1'b0;
        bus1.btn = 1'b0;
        step();
        check("idle_busy", 32'(bus1.busy), 32'd0);

        for (int i = 0; i < 9; i++) run_round(vecs[i], i);

        // Reset in ARMED with time_ms=2 returns straight to IDLE.
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int i = 1; i <= 16; i++) step();
        check("armed_led",  32'(bus1.led), 32'd1);
        check("armed_time", 32'(bus1.time_ms), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_led",  32'(bus1.led), 32'd0);
        check("midrst_time", 32'(bus1.time_ms), 32'd0);
        check("midrst_busy", 32'(bus1.busy), 32'd0);
        check("midrst_done", 32'(bus1.done), 32'd0);
        step();
        check("midrst_idle", 32'(bus1.busy), 32'd0);

        // Button already high before the round is not a press.
        run_round(held, 9);

        // Randomised waits on the second instance (2 cycles per ms).
        for (int r = 0; r < 16; r++) begin
            bus2.start = 1'b1;
            step();
            bus2.start = 1'b0;
            k = 0;
            while (!bus2.led && k < 5000) begin
                step();
                k++;
            end
            check($sformatf("rnd%0d_led", r), 32'(bus2.led), 32'd1);
            check($sformatf("rnd%0d_even", r), 32'(k % 2), 32'd0);
            waits[r] = k / 2;
            check($sformatf("rnd%0d_range_w%0d", r, waits[r]),
                  32'((waits[r] >= 2) && (waits[r] <= 2049)), 32'd1);
            bus2.btn = 1'b1;
            step();
            check($sformatf("rnd%0d_done", r), 32'(bus2.done), 32'd1);
            bus2.btn = 1'b0;
            step();
            step();
        end
        all_same = 1;
        for (int r = 1; r < 16; r++) if (waits[r] != waits[0]) all_same = 0;
        check("rnd_spread", 32'(all_same), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
